vamk_assign_engine: RTL

//  Hardware variable table for the vamk build evaluator. Applies assignments of four kinds to NUM_VARS

---
 rtl/vamk_assign_engine.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/vamk_assign_engine.sv
// vamk_assign_engine: byte-string variable table applying '=', ':=', '?=' and '+=' from a
// pre-expanded byte stream, with a registered random-access read port for the recipe builder.
module vamk_assign_engine #(
  parameter  int NUM_VARS = 16,
  parameter  int MAX_LEN  = 32,
  localparam int IDX_W    = $clog2(NUM_VARS),
  localparam int LEN_W    = $clog2(MAX_LEN+1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [2:0]       i_cmd_op,
  input  logic [IDX_W-1:0] i_cmd_idx,
  input  logic             i_cmd_empty,
  input  logic             i_dat_valid,
  output logic             o_dat_ready,
  input  logic [7:0]       i_dat_byte,
  input  logic             i_dat_last,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [1:0]       o_rsp_status,
  output logic [LEN_W-1:0] o_rsp_len,
  input  logic             i_rd_en,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic [LEN_W-1:0] i_rd_pos,
  output logic [7:0]       o_rd_byte,
  output logic [LEN_W-1:0] o_rd_len,
  output logic             o_rd_defined
);
  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [1:0] ST_OK = 2'd0, ST_SKIP = 2'd1, ST_TRUNC = 2'd2, ST_ILL = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_SEP, S_DATA, S_RESP} state_t;

  state_t              r_state, w_nstate;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [LEN_W-1:0]    r_wptr, w_wptr_nxt;
  logic                r_trunc, w_trunc_nxt, r_skip, w_skip_nxt, r_ill, w_ill_nxt, r_empty, w_empty_nxt;
  logic                r_cmd_rdy, r_dat_rdy, r_rsp_valid;
  logic [1:0]          r_rsp_status, w_status;
  logic [LEN_W-1:0]    r_rsp_len, w_rsp_len;
  logic [LEN_W-1:0]    r_len [NUM_VARS];
  logic [NUM_VARS-1:0] r_def;
  logic [7:0]          r_mem [NUM_VARS][MAX_LEN];
  logic                w_wr_en, w_full, w_commit, w_app;
  logic [7:0]          w_wr_byte;
  logic [7:0]          r_rd_byte;
  logic [LEN_W-1:0]    r_rd_len;
  logic                r_rd_def;

  assign o_cmd_ready  = r_cmd_rdy & ~i_clr;
  assign o_dat_ready  = r_dat_rdy;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_status = r_rsp_status;
  assign o_rsp_len    = r_rsp_len;
  assign o_rd_byte    = r_rd_byte;
  assign o_rd_len     = r_rd_len;
  assign o_rd_defined = r_rd_def;

  assign w_full = (r_wptr >= LEN_W'(MAX_LEN));
  assign w_app  = (i_cmd_op == 3'd3) & r_def[i_cmd_idx];

  always_comb begin
    w_nstate    = r_state;
    w_idx_nxt   = r_idx;
    w_wptr_nxt  = r_wptr;
    w_trunc_nxt = r_trunc;
    w_skip_nxt  = r_skip;
    w_ill_nxt   = r_ill;
    w_empty_nxt = r_empty;
    w_wr_en     = 1'b0;
    w_wr_byte   = i_dat_byte;
    case (r_state)
      S_IDLE: if (o_cmd_ready && i_cmd_valid) begin
        w_idx_nxt   = i_cmd_idx;
        w_ill_nxt   = i_cmd_op[2];
        w_skip_nxt  = (i_cmd_op == 3'd2) & r_def[i_cmd_idx];
        w_empty_nxt = i_cmd_empty;
        w_trunc_nxt = 1'b0;
        w_wptr_nxt  = w_app ? r_len[i_cmd_idx] : '0;
        w_nstate    = w_app ? S_SEP : (i_cmd_empty ? S_RESP : S_DATA);
      end
      S_SEP: begin
        if (!w_full) begin
          w_wr_en    = 1'b1;
          w_wr_byte  = 8'h20;
          w_wptr_nxt = r_wptr + 1'b1;
        end else w_trunc_nxt = 1'b1;
        w_nstate = r_empty ? S_RESP : S_DATA;
      end
      S_DATA: if (i_dat_valid) begin
        // skip/illegal ops still drain their beats, they just never touch storage
        if (!w_full) begin
          w_wr_en    = ~r_skip & ~r_ill;
          w_wptr_nxt = r_wptr + 1'b1;
        end else w_trunc_nxt = 1'b1;
        if (i_dat_last) w_nstate = S_RESP;
      end
      S_RESP: if (i_rsp_ready) w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  assign w_commit  = (r_state != S_RESP) && (w_nstate == S_RESP);
  assign w_status  = w_ill_nxt ? ST_ILL : w_skip_nxt ? ST_SKIP : w_trunc_nxt ? ST_TRUNC : ST_OK;
  assign w_rsp_len = (w_ill_nxt | w_skip_nxt) ? r_len[w_idx_nxt] : w_wptr_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_wptr       <= '0;
      r_trunc      <= 1'b0;
      r_skip       <= 1'b0;
      r_ill        <= 1'b0;
      r_empty      <= 1'b0;
      r_cmd_rdy    <= 1'b0;
      r_dat_rdy    <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_status <= '0;
      r_rsp_len    <= '0;
      r_def        <= '0;
      for (int i = 0; i < NUM_VARS; i++) r_len[i] <= '0;
    end else begin
      r_state   <= w_nstate;
      r_idx     <= w_idx_nxt;
      r_wptr    <= w_wptr_nxt;
      r_trunc   <= w_trunc_nxt;
      r_skip    <= w_skip_nxt;
      r_ill     <= w_ill_nxt;
      r_empty   <= w_empty_nxt;
      r_cmd_rdy <= (w_nstate == S_IDLE);
      r_dat_rdy <= (w_nstate == S_DATA);
      if (w_commit) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_status <= w_status;
        r_rsp_len    <= w_rsp_len;
        if (!w_ill_nxt && !w_skip_nxt) begin
          r_len[w_idx_nxt] <= w_wptr_nxt;
          r_def[w_idx_nxt] <= 1'b1;
        end
      end else if (r_state == S_RESP && i_rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
      if (r_state == S_IDLE && i_clr) begin
        r_def <= '0;
        for (int i = 0; i < NUM_VARS; i++) r_len[i] <= '0;
      end
    end
  end

  // byte storage is only meaningful below the committed length, so it needs no reset
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_idx][r_wptr[PTR_W-1:0]] <= w_wr_byte;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_byte <= '0;
      r_rd_len  <= '0;
      r_rd_def  <= 1'b0;
    end else if (i_rd_en) begin
      r_rd_byte <= (i_rd_pos < LEN_W'(MAX_LEN)) ? r_mem[i_rd_idx][i_rd_pos[PTR_W-1:0]] : 8'h00;
      r_rd_len  <= r_len[i_rd_idx];
      r_rd_def  <= r_def[i_rd_idx];
    end
  end
endmodule
